// File: rtl/mac3_seq_pkg.sv
// Shared types and constants for the 9-tap MAC sequencer.
package mac3_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int MAC_LATENCY_DEFAULT = 5;
  localparam int FLUSH_BEATS         = 2;

endpackage

// File: rtl/mac3_valid_tracker.sv
// Follows each window through the MAC pipeline; out_valid marks a finished result.
// Stages 1-2 advance only on MAC input beats, the remaining stages free-run every cycle.
module mac3_valid_tracker
  import mac3_seq_pkg::*;
#(
  parameter int MAC_LATENCY = MAC_LATENCY_DEFAULT
) (
  input  logic clk,
  input  logic arst_n_in,
  input  logic beat,
  input  logic real_beat,
  output logic out_valid,
  output logic empty
);

  localparam int TW = MAC_LATENCY - 2;

  logic          t1;
  logic          t2;
  logic [TW-1:0] tail;

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      t1   <= 1'b0;
      t2   <= 1'b0;
      tail <= '0;
    end else begin
      if (beat) begin
        t1 <= real_beat;
        t2 <= t1;
      end
      // stage 3 captures only when a beat pushes stage 2 forward
      tail <= {tail[TW-2:0], t2 & beat};
    end
  end

  assign out_valid = tail[TW-1];
  assign empty     = !(t1 | t2 | (|tail));

endmodule

// File: rtl/mac3_seq.sv
// Job controller for a 9-tap MAC: issues num_items windows, two zero flush beats, then drains results.
// Optional stall_cycles counter is built when MAC3_SEQ_PERF_EN is defined.
module mac3_seq
  import mac3_seq_pkg::*;
#(
  parameter int CNT_WIDTH   = 16,
  parameter int MAC_LATENCY = MAC_LATENCY_DEFAULT
) (
  input  logic                 clk,
  input  logic                 arst_n_in,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] num_items,
  input  logic                 op_valid,
  output logic                 op_ready,
  output logic                 mac_input_valid,
  output logic                 mac_zero_operands,
  output logic                 out_valid,
  output logic [CNT_WIDTH-1:0] result_count,
  output logic                 busy,
  output logic                 done
`ifdef MAC3_SEQ_PERF_EN
  ,
  output logic [31:0]          stall_cycles
`endif
);

  state_t               state;
  state_t               state_nxt;
  logic [CNT_WIDTH-1:0] items_q;
  logic [CNT_WIDTH-1:0] issued;
  logic [1:0]           flush_cnt;
  logic                 last_beat;
  logic                 real_beat;
  logic                 trk_empty;

  // one extra bit so a full-range job cannot wrap the comparison
  assign last_beat = (({1'b0, issued} + 1'b1) == {1'b0, items_q});
  assign real_beat = (state == S_RUN) && op_valid;

  always_comb begin
    state_nxt         = state;
    op_ready          = 1'b0;
    mac_input_valid   = 1'b0;
    mac_zero_operands = 1'b0;
    busy              = 1'b1;
    done              = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = (num_items == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        op_ready        = 1'b1;
        mac_input_valid = op_valid;
        if (op_valid && last_beat) state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        mac_input_valid   = 1'b1;
        mac_zero_operands = 1'b1;
        if (flush_cnt == 2'(FLUSH_BEATS - 1)) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (trk_empty && (result_count == items_q)) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state        <= S_IDLE;
      items_q      <= '0;
      issued       <= '0;
      flush_cnt    <= '0;
      result_count <= '0;
    end else begin
      state <= state_nxt;
      if ((state == S_IDLE) && start) begin
        items_q      <= num_items;
        issued       <= '0;
        flush_cnt    <= '0;
        result_count <= '0;
      end else begin
        if (real_beat) issued <= issued + 1'b1;
        if (state == S_FLUSH) flush_cnt <= flush_cnt + 1'b1;
        if (out_valid) result_count <= result_count + 1'b1;
      end
    end
  end

`ifdef MAC3_SEQ_PERF_EN
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      stall_cycles <= '0;
    end else if ((state == S_IDLE) && start) begin
      stall_cycles <= '0;
    end else if ((state == S_RUN) && !op_valid && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end
`endif

  mac3_valid_tracker #(
    .MAC_LATENCY(MAC_LATENCY)
  ) u_tracker (
    .clk      (clk),
    .arst_n_in(arst_n_in),
    .beat     (mac_input_valid),
    .real_beat(real_beat),
    .out_valid(out_valid),
    .empty    (trk_empty)
  );

endmodule

// File: tb/tb_mac3_seq.sv
// Self-checking bench for mac3_seq against a per-job timing model derived from beat positions.
module tb_mac3_seq;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          arst_n_in;
  logic          start;
  logic [CW-1:0] num_items;
  logic          op_valid;
  logic          op_ready;
  logic          mac_input_valid;
  logic          mac_zero_operands;
  logic          out_valid;
  logic [CW-1:0] result_count;
  logic          busy;
  logic          done;
`ifdef MAC3_SEQ_PERF_EN
  logic [31:0]   stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mac3_seq #(
    .CNT_WIDTH(CW)
  ) dut (
    .clk              (clk),
    .arst_n_in        (arst_n_in),
    .start            (start),
    .num_items        (num_items),
    .op_valid         (op_valid),
    .op_ready         (op_ready),
    .mac_input_valid  (mac_input_valid),
    .mac_zero_operands(mac_zero_operands),
    .out_valid        (out_valid),
    .result_count     (result_count),
    .busy             (busy),
    .done             (done)
`ifdef MAC3_SEQ_PERF_EN
    ,
    .stall_cycles     (stall_cycles)
`endif
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Cycle 0 is the first cycle after the edge that samples start.
  // A window becomes a result 3 cycles after the second MAC beat that follows it.
  task automatic run_job(input int n, input bit use_pat, input logic [63:0] pat,
                         input int restart_at, input int stall_pct);
    bit opv[128];
    bit eov[128];
    int beats[64];
    int nb = 0, issued = 0, c = 0, runlast, f, done_c, rc = 0, exp_stall = 0;
    bit in_run, in_flush;
    for (int i = 0; i < 128; i++) begin
      opv[i] = 1'b0;
      eov[i] = 1'b0;
    end
    while (issued < n) begin
      if (use_pat) opv[c] = pat[c];
      else opv[c] = ($urandom_range(99) >= stall_pct) || (c >= 100);
      if (opv[c]) begin
        beats[nb] = c;
        nb++;
        issued++;
      end else begin
        exp_stall++;
      end
      c++;
    end
    runlast = c - 1;
    f = c;
    beats[nb] = f;
    beats[nb+1] = f + 1;
    for (int j = 0; j < n; j++) eov[beats[j+2] + 3] = 1'b1;
    done_c = (n == 0) ? 0 : f + 6;

    @(posedge clk);
    #1;
    start = 1'b1;
    num_items = CW'(n);
    op_valid = 1'($urandom);
    @(negedge clk);
    chk1("idle_busy", busy, 1'b0);
    chk1("idle_op_ready", op_ready, 1'b0);
    chk1("idle_mac_input_valid", mac_input_valid, 1'b0);

    for (int cc = 0; cc <= done_c + 1; cc++) begin
      @(posedge clk);
      #1;
      start = (cc == restart_at);
      num_items = CW'($urandom);
      op_valid = (cc <= runlast) ? opv[cc] : 1'($urandom);
      @(negedge clk);
      in_run = (cc <= runlast);
      in_flush = (n > 0) && ((cc == f) || (cc == f + 1));
      chk1("op_ready", op_ready, in_run);
      chk1("mac_input_valid", mac_input_valid, (in_run && opv[cc]) || in_flush);
      chk1("mac_zero_operands", mac_zero_operands, in_flush);
      chk1("out_valid", out_valid, eov[cc]);
      chk1("done", done, cc == done_c);
      chk1("busy", busy, cc <= done_c);
      chkn("result_count", 32'(result_count), rc);
      if (eov[cc]) rc++;
`ifdef MAC3_SEQ_PERF_EN
      if (cc == done_c + 1) chkn("stall_cycles", stall_cycles, exp_stall);
`endif
    end
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] ones;
    ones = '1;
    arst_n_in = 1'b0;
    start = 1'b0;
    num_items = '0;
    op_valid = 1'b0;
    #12;
    chk1("rst_op_ready", op_ready, 1'b0);
    chk1("rst_mac_input_valid", mac_input_valid, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chkn("rst_result_count", 32'(result_count), 0);
    @(negedge clk);
    arst_n_in = 1'b1;

    run_job(4, 1'b1, ones, -1, 0);
    run_job(3, 1'b1, 64'b110001, -1, 0);
    run_job(0, 1'b1, ones, -1, 0);
    run_job(1, 1'b1, ones, -1, 0);
    run_job(5, 1'b1, ones, 2, 0);
    run_job(15, 1'b0, 64'd0, -1, 30);
    for (int k = 0; k < 8; k++)
      run_job($urandom_range(1, 15), 1'b0, 64'd0, int'($urandom_range(0, 4)), int'($urandom_range(0, 60)));

    // Reset while flushing: abandon the job entirely.
    @(posedge clk);
    #1;
    start = 1'b1;
    num_items = 3;
    op_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    chk1("pre_rst_flush", mac_zero_operands, 1'b1);
    arst_n_in = 1'b0;
    #1;
    chk1("midrst_mac_input_valid", mac_input_valid, 1'b0);
    chk1("midrst_mac_zero_operands", mac_zero_operands, 1'b0);
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_op_ready", op_ready, 1'b0);
    chkn("midrst_result_count", 32'(result_count), 0);
    @(negedge clk);
    arst_n_in = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      op_valid = 1'($urandom);
      @(negedge clk);
      chk1("postrst_out_valid", out_valid, 1'b0);
      chk1("postrst_done", done, 1'b0);
      chk1("postrst_busy", busy, 1'b0);
      chk1("postrst_mac_input_valid", mac_input_valid, 1'b0);
    end
    run_job(2, 1'b0, 64'd0, -1, 40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
